nes_pad_reader: RTL and testbench

NES_PAD_READER -- requirements
Module: nes_pad_reader

---
 rtl/nespad_pkg.sv | 7 +
 rtl/nespad_tick_gen.sv | 16 +
 rtl/nes_pad_reader.sv | 84 ++++++++
 tb/tb_nes_pad_reader.sv | 118 +++++++++++
 4 files changed

// File: rtl/nespad_pkg.sv
// nespad_pkg: shared FSM state type and frame geometry for the NES pad reader
package nespad_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLK_LOW, DONE} state_t;
  localparam int LATCH_TICKS = 2;
  localparam int NUM_BITS = 16;
  localparam int FRAME_TICKS = 33;
endpackage

// File: rtl/nespad_tick_gen.sv
// nespad_tick_gen: free-running prescaler emitting a one-clk tick every TICK_DIV clks
module nespad_tick_gen #(
  parameter int TICK_DIV = 150
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == W'(TICK_DIV - 1);
  // wrap the counter on the tick so ticks are exactly TICK_DIV clks apart
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES pad via latch/clock/data; NESPAD_DEBOUNCE_EN requires two equal frames before updating
import nespad_pkg::*;
module nes_pad_reader #(
  parameter int TICK_DIV   = 150,
  parameter int POLL_TICKS = 2778
) (
  input  logic        clk,
  input  logic        reset,
  output logic        nesc,
  output logic        nesl,
  input  logic        nesd,
  output logic [15:0] nesState
);
  localparam int CW = $clog2(POLL_TICKS > LATCH_TICKS ? POLL_TICKS : LATCH_TICKS);
  localparam int KW = $clog2(NUM_BITS);
  state_t                r_state, w_state_n;
  logic                  w_tick, w_cnt_last;
  logic [CW-1:0]         r_cnt;
  logic [KW-1:0]         r_k;
  logic [NUM_BITS-1:0]   r_shift, r_nes_state;
  logic [1:0]            r_sync;
  logic                  r_nesc, r_nesl;
  nespad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(w_tick));
  assign w_cnt_last = r_cnt == CW'(r_state == LATCH ? LATCH_TICKS - 1 : POLL_TICKS - 1);
  assign nesc = r_nesc;
  assign nesl = r_nesl;
  assign nesState = r_nes_state;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_n;
  // next state: DONE leaves after one clk, every other move waits for a tick
  always_comb begin
    w_state_n = r_state;
    if (r_state == DONE) w_state_n = IDLE;
    else if (w_tick)
      w_state_n = r_state == IDLE    ? (w_cnt_last ? LATCH : IDLE) :
                  r_state == LATCH   ? (w_cnt_last ? SAMPLE : LATCH) :
                  r_state == SAMPLE  ? (r_k == KW'(NUM_BITS - 1) ? DONE : CLK_LOW) :
                  r_state == CLK_LOW ? SAMPLE : IDLE;
  end
  // pad pins are decoded from the next state so they are registered yet aligned with the state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_nesc <= 1'b1;
      r_nesl <= 1'b0;
    end else begin
      r_nesc <= w_state_n != CLK_LOW;
      r_nesl <= w_state_n == LATCH;
    end
  // two-flop synchronizer; idles high like a released line
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], nesd};
  // tick counter for IDLE/LATCH, bit index and shift capture
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt   <= '0;
      r_k     <= '0;
      r_shift <= '0;
    end else begin
      if (w_tick && (r_state == IDLE || r_state == LATCH)) r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      if (r_state == LATCH) r_k <= '0;
      else if (r_state == CLK_LOW && w_tick) r_k <= r_k + 1'b1;
      if (r_state == SAMPLE && w_tick) r_shift[r_k] <= r_sync[1];
    end
`ifdef NESPAD_DEBOUNCE_EN
  logic [NUM_BITS-1:0] r_prev;
  // publish only when two consecutive frames agree
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_nes_state <= '0;
      r_prev      <= '0;
    end else if (r_state == DONE) begin
      r_prev <= ~r_shift;
      if (~r_shift == r_prev) r_nes_state <= ~r_shift;
    end
`else
  // publish every completed frame
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_nes_state <= '0;
    else if (r_state == DONE) r_nes_state <= ~r_shift;
`endif
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: pad model plus scoreboard for nes_pad_reader (TICK_DIV=4, POLL_TICKS=8)
module tb_nes_pad_reader;
  logic clk = 1'b0, reset = 1'b1, nesd = 1'b1;
  logic nesc, nesl;
  logic [15:0] nesState;
  always #5 clk = ~clk;
  nes_pad_reader #(.TICK_DIV(4), .POLL_TICKS(8)) dut (
    .clk(clk), .reset(reset), .nesc(nesc), .nesl(nesl), .nesd(nesd), .nesState(nesState)
  );
  int n_tests = 0, n_fail = 0;
  logic [15:0] pad_q[$], exp_q[$];
  logic [15:0] pad_tab [11] = '{16'h0009, 16'h0009, 16'h0000, 16'h0000, 16'h0001, 16'h0002,
                                16'h0001, 16'h0002, 16'hA5A5, 16'h8001, 16'h8001};
`ifdef NESPAD_DEBOUNCE_EN
  logic [15:0] exp_tab [10] = '{16'h0000, 16'h0009, 16'h0009, 16'h0000, 16'h0000, 16'h0000,
                                16'h0000, 16'h0000, 16'h0000, 16'h8001};
`else
  logic [15:0] exp_tab [10] = '{16'h0009, 16'h0009, 16'h0000, 16'h0000, 16'h0001, 16'h0002,
                                16'h0001, 16'h0002, 16'h8001, 16'h8001};
`endif
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  logic pc = 1'b1, pl = 1'b0, frame_valid = 1'b0;
  int lcnt = 0, ccnt = 0, period = 0, pulses = 0, falls = 0, countdown = 0, idx = 16, frames_checked = 0;
  logic [15:0] pressed = '0, last_exp = '0;
  // pad model, pin timing checks and scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      frame_valid = 1'b0;
      pulses = 0; falls = 0; countdown = 0; lcnt = 0; ccnt = 0;
      last_exp = '0; pc = nesc; pl = nesl;
    end else begin
      period++;
      if (nesl && !pl) begin
        if (frame_valid) begin
          check("latch_period", period, 164);
          check("pulses_per_frame", pulses, 15);
        end
        check("held_state", nesState, last_exp);
        frame_valid = 1'b1; period = 0; pulses = 0; falls = 0; idx = 0;
        pressed = pad_q.size() > 0 ? pad_q.pop_front() : 16'h0000;
      end
      if (nesl) lcnt++;
      else if (pl) begin
        check("latch_width", lcnt, 8);
        lcnt = 0;
      end
      if (!nesc) begin
        ccnt++;
        if (pc) falls++;
      end else if (!pc) begin
        check("clk_low_width", ccnt, 4);
        ccnt = 0; pulses++; idx++;
        if (pulses == 15) countdown = 8;
      end
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          frames_checked++;
          if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check("nesState", nesState, last_exp);
          end else begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_frame: got frame %0d expected none", frames_checked);
          end
        end
      end
      nesd = idx < 16 ? ~pressed[idx] : 1'b1;
      pc = nesc; pl = nesl;
    end
  end
  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && frames_checked < n; i++) @(negedge clk);
    check("frames_done", frames_checked, n);
  endtask
  initial begin
    int n;
    #2 reset = 1'b0;
    #1;
    check("rst_nesState", nesState, 16'h0000);
    check("rst_nesc", nesc, 1);
    check("rst_nesl", nesl, 0);
    foreach (pad_tab[i]) pad_q.push_back(pad_tab[i]);
    foreach (exp_tab[i]) exp_q.push_back(exp_tab[i]);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_frames(8);
    for (int i = 0; i < 400 && !nesl; i++) @(negedge clk);
    for (int i = 0; i < 200 && falls != 8; i++) @(negedge clk);
    check("reached_bit7", falls, 8);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_nesState", nesState, 16'h0000);
    check("abort_nesc", nesc, 1);
    check("abort_nesl", nesl, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (nesl) break;
    end
    check("first_latch_delay", n, 32);
    wait_frames(10);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
